key_event_arbiter: RTL and testbench
====================================

KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 The block SHALL have parameter DURATION, default 10, giving debounce length in clk_i cycles (50 ms at a 5 ms tick).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 100, giving cycles from debounced press to first auto-repeat.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 20, giving cycles between subsequent auto-repeats.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the only clock, a 5 ms tick; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port key_i, input, 4 bits: raw key levels, active-high, one bit per key.
REQ-008 The block SHALL have port key_ack_i, input, 1 bit: consumer accepts the presented event.
REQ-009 The block SHALL have port pressed_o, output, 4 bits: debounced key levels, active-high.
REQ-010 The block SHALL have port key_valid_o, output, 1 bit: an event is presented on key_code_o.
REQ-011 The block SHALL have port key_code_o, output, 2 bits: index of the key that produced the presented event.
REQ-012 The block SHALL have port ovf_o, output, 1 bit: one-cycle pulse when an event is lost.

Function
REQ-013 The block SHALL keep one 4-bit counter per key: +1 while key_i[k]=1, saturating at DURATION, cleared to 0 the cycle key_i[k]=0.
REQ-014 The block SHALL drive pressed_o[k] = (cnt[k]==DURATION), registered, so a steady press asserts it on the DURATION-th rising edge with key_i[k] high.
REQ-015 The block SHALL set pend[k] on the same edge where cnt[k] goes DURATION-1 -> DURATION (press event).
REQ-016 The block SHALL keep a pending event set when the key is released before service.
REQ-017 The block SHALL grant one pending key on the next edge when key_valid_o=0 and any pend bit is set.
- Winner: first set bit at or above a 2-bit round-robin pointer ptr, ascending, modulo 4.
- On grant: key_code_o = winner, key_valid_o = 1, pend[winner] cleared, ptr = winner+1 mod 4.
REQ-018 The block SHALL hold key_valid_o and key_code_o stable until key_ack_i=1 is sampled with key_valid_o=1.
REQ-019 The block SHALL deassert key_valid_o on the edge after that ack.
- The next grant occurs no earlier than the following edge, so key_valid_o is low for at least one cycle between events.
REQ-020 The block SHALL ignore key_ack_i while key_valid_o=0.
REQ-021 The block SHALL pulse ovf_o high for one cycle if a new event for key k arrives while pend[k]=1; no duplicate is queued.
REQ-022 The block SHALL let set win on the edge where pend[k] is cleared by a grant and a new event for k arrives: pend[k] stays 1 and ovf_o stays 0.
REQ-023 The block SHALL handle multiple keys reaching DURATION on the same edge by setting all their pend bits and serving them in round-robin order.

Reset
REQ-024 The block SHALL, on an rst_i=1 edge, clear all debounce counters, pend, ptr, pressed_o, key_valid_o, key_code_o, ovf_o and repeat counters to 0.
REQ-025 The block SHALL, with key_i held high through reset, start counting on the first edge with rst_i=0; reset mid-debounce discards the partial count and any pending or presented event.

Configuration
REQ-026 The block SHALL, with macro KEY_REPEAT_EN defined, keep one 8-bit repeat counter per key, cleared while pressed_o[k]=0.
- A repeat event is raised REPEAT_DELAY edges after pressed_o[k] rises, then every REPEAT_PERIOD edges while held.
- Repeat events use the same pend/ovf rules as press events.
REQ-027 The block SHALL, without KEY_REPEAT_EN, implement no repeat counters, generate exactly one event per debounced press, and leave REPEAT_DELAY and REPEAT_PERIOD unused.

Verification
REQ-028 Bench SHALL check: key_i=0001 from edge 1 -> pressed_o[0]=1 after edge 10, key_valid_o=1 with key_code_o=0 after edge 11; key_ack_i=1 at edge 14 -> key_valid_o=0 after edge 14.
REQ-029 Bench SHALL check: key_i[1] high 9 edges, low 1, high 10 -> exactly one event with code 1; no pressed_o pulse during the bounce.
REQ-030 Bench SHALL check: key_i[0] and key_i[2] rise on the same edge with ptr=0 and acks immediate -> code 0 first, then code 2 after the idle cycle.
REQ-031 Bench SHALL check: event code 3 held unacked while key 1 is pressed, released and pressed again -> first press pending, second press gives ovf_o=1 for exactly one cycle, only one code-1 event delivered.
REQ-032 Bench SHALL check: rst_i=1 at edge 5 of a key-0 press, key held -> no event; pressed_o[0] rises 10 edges after reset release.
REQ-033 Bench SHALL check (KEY_REPEAT_EN): key 3 held 150 edges after pressed_o[3] rises, immediate acks -> events at +0, +100, +120, +140; none after release.

Source files
------------

// File: rtl/key_event_arbiter.sv
// -----------------------------------------------------------------------------
// key_event_arbiter
//
// Debounces four raw active-high key inputs, turns each debounced press into a
// single event, and presents pending events one at a time to a consumer using
// a valid/ack handshake with round-robin selection between keys.
//
// Optional feature (macro KEY_REPEAT_EN): while a key stays debounced-pressed,
// extra auto-repeat events are raised REPEAT_DELAY cycles after the press and
// then every REPEAT_PERIOD cycles. Without the macro, each debounced press
// produces exactly one event and the repeat parameters are unused.
//
// Parameters
//   DURATION      debounce length in clk_i cycles (1..15)
//   REPEAT_DELAY  cycles from debounced press to first auto-repeat (1..256)
//   REPEAT_PERIOD cycles between later auto-repeats (1..REPEAT_DELAY)
//
// Ports
//   clk_i        in   1  clock (5 ms tick), all state on rising edge
//   rst_i        in   1  synchronous active-high reset
//   key_i        in   4  raw key levels, active-high
//   key_ack_i    in   1  consumer accepts the presented event
//   pressed_o    out  4  debounced key levels
//   key_valid_o  out  1  an event is presented on key_code_o
//   key_code_o   out  2  index of the key that produced the presented event
//   ovf_o        out  1  one-cycle pulse when an event is lost
// -----------------------------------------------------------------------------
module key_event_arbiter #(
    parameter int DURATION      = 10,
    parameter int REPEAT_DELAY  = 100,
    parameter int REPEAT_PERIOD = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] key_i,
    input  logic       key_ack_i,
    output logic [3:0] pressed_o,
    output logic       key_valid_o,
    output logic [1:0] key_code_o,
    output logic       ovf_o
);

    localparam logic [3:0] DUR    = 4'(DURATION);
    localparam logic [3:0] DUR_M1 = 4'(DURATION - 1);

    // Per-key event strobe (press or repeat) feeding the pending set.
    logic [3:0] evt;

    // -------------------------------------------------------------------------
    // Per-key debounce and (optionally) auto-repeat
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic [3:0] cnt_q, cnt_d;
            logic       pressed_q, pressed_d;
            logic       press_evt;

            always_comb begin
                cnt_d = 4'd0;
                if (key_i[gi]) begin
                    cnt_d = (cnt_q == DUR) ? cnt_q : cnt_q + 4'd1;
                end
            end

            // pressed follows the counter's next value so it rises on the
            // same edge the counter reaches DURATION.
            assign pressed_d = (cnt_d == DUR);
            assign press_evt = key_i[gi] && (cnt_q == DUR_M1);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q     <= 4'd0;
                    pressed_q <= 1'b0;
                end else begin
                    cnt_q     <= cnt_d;
                    pressed_q <= pressed_d;
                end
            end

            assign pressed_o[gi] = pressed_q;

`ifdef KEY_REPEAT_EN
            localparam logic [7:0] RD_M1  = 8'(REPEAT_DELAY - 1);
            localparam logic [7:0] RELOAD = 8'(REPEAT_DELAY - REPEAT_PERIOD);

            logic [7:0] rcnt_q, rcnt_d;
            logic       rep_evt;

            // rcnt counts edges since pressed rose. On reaching the delay it
            // is reloaded so the next hit is REPEAT_PERIOD edges later.
            // Gating with pressed_d suppresses a repeat on the release edge.
            always_comb begin
                rcnt_d  = 8'd0;
                rep_evt = 1'b0;
                if (pressed_q && pressed_d) begin
                    if (rcnt_q == RD_M1) begin
                        rep_evt = 1'b1;
                        rcnt_d  = RELOAD;
                    end else begin
                        rcnt_d = rcnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rcnt_q <= 8'd0;
                end else begin
                    rcnt_q <= rcnt_d;
                end
            end

            assign evt[gi] = press_evt | rep_evt;
`else
            assign evt[gi] = press_evt;
`endif
        end
    endgenerate

`ifndef KEY_REPEAT_EN
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // -------------------------------------------------------------------------
    // Pending set, round-robin grant and valid/ack handshake
    // -------------------------------------------------------------------------
    logic [3:0] pend_q, pend_d;
    logic [1:0] ptr_q, ptr_d;
    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;
    logic       ovf_q, ovf_d;

    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       grant;
    logic [3:0] grant_clr;

    // First pending key at or above ptr, ascending, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant     = !valid_q && found;
    assign grant_clr = grant ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        // A new event on the same edge as its grant re-sets pend (set wins),
        // and is not counted as lost.
        pend_d  = (pend_q & ~grant_clr) | evt;
        ovf_d   = |(evt & pend_q & ~grant_clr);
        valid_d = valid_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        if (grant) begin
            valid_d = 1'b1;
            code_d  = win;
            ptr_d   = win + 2'd1;
        end else if (valid_q && key_ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 4'd0;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign key_valid_o = valid_q;
    assign key_code_o  = code_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for key_event_arbiter. Expected event codes are queued
// when a press is driven and popped when the DUT presents an event. Outputs
// are sampled 1 time unit after each rising edge; inputs change at that point.
// -----------------------------------------------------------------------------
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       ack;
    logic [3:0] pressed;
    logic       valid;
    logic [1:0] code;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];

    key_event_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .key_i      (key),
        .key_ack_i  (ack),
        .pressed_o  (pressed),
        .key_valid_o(valid),
        .key_code_o (code),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key = 4'b0000;
        ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Returns X when nothing is queued so any real code mismatches.
    function automatic logic [1:0] pop_exp();
        if (exp_q.size() == 0) return 2'bxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        logic [1:0] e;
        rst = 1'b0;
        ack = 1'b0;
        key = 4'b1111;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: actual=%b required=1", valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        key = 4'b0000;
        e = 2'd0;
        checks++;
        if (pressed !== 4'b0000 || valid !== 1'b0 || code !== e || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: actual=p%b v%b c%0d o%b required=p0000 v0 c0 o0",
                     pressed, valid, code, ovf);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [1:0] e;
        int bad_valid = 0;
        do_reset();
        key = 4'b0001;
        exp_q.push_back(2'd0);
        for (int t = 1; t <= 10; t++) begin
            tick();
            checks++;
            if (pressed[0] !== (t == 10)) begin
                failures++;
                $display("FAIL basic_pressed_e%0d: actual=%b required=%b", t, pressed[0], (t == 10));
            end
            if (valid) bad_valid++;
        end
        checks++;
        if (bad_valid != 0) begin
            failures++;
            $display("FAIL basic_early_valid: actual=%0d required=0", bad_valid);
        end
        tick();  // edge 11
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL basic_event: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        tick();
        tick();  // edge 13, still unacked
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL basic_hold: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        ack = 1'b1;
        tick();  // edge 14
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_ack: actual=%b required=0", valid);
        end
        key = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        $display("test_basic: done");
    endtask

    task automatic test_bounce();
        logic [1:0] e;
        int bad_p = 0;
        int bad_v = 0;
        int extra = 0;
        do_reset();
        key = 4'b0010;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (pressed !== 4'b0000) bad_p++;
            if (valid) bad_v++;
        end
        key = 4'b0000;
        tick();
        if (pressed !== 4'b0000) bad_p++;
        key = 4'b0010;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (pressed !== 4'b0000) bad_p++;
            if (valid) bad_v++;
        end
        checks++;
        if (bad_p != 0 || bad_v != 0) begin
            failures++;
            $display("FAIL bounce_quiet: actual=p%0d v%0d required=p0 v0", bad_p, bad_v);
        end
        exp_q.push_back(2'd1);
        tick();
        checks++;
        if (pressed !== 4'b0010) begin
            failures++;
            $display("FAIL bounce_pressed: actual=%b required=0010", pressed);
        end
        tick();
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL bounce_event: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        key = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL bounce_single: actual=%0d extra required=0", extra);
        end
        $display("test_bounce: done");
    endtask

    task automatic test_same_edge();
        logic [1:0] e;
        do_reset();
        key = 4'b0101;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (pressed !== 4'b0101) begin
            failures++;
            $display("FAIL same_pressed: actual=%b required=0101", pressed);
        end
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        tick();
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL same_first: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL same_idle: actual=%b required=0", valid);
        end
        tick();
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL same_second: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        key = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        $display("test_same_edge: done");
    endtask

    task automatic test_overflow();
        logic [1:0] e;
        logic [1:0] held;
        int early_ovf = 0;
        int extra = 0;
        do_reset();
        key = 4'b1000;
        for (int i = 0; i < 10; i++) tick();
        exp_q.push_back(2'd3);
        tick();
        held = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== held) begin
            failures++;
            $display("FAIL ovf_held_event: actual=v%b c%0d required=v1 c%0d", valid, code, held);
        end
        key = 4'b0010;
        exp_q.push_back(2'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ovf) early_ovf++;
        end
        key = 4'b0000;
        tick();
        if (ovf) early_ovf++;
        key = 4'b0010;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (ovf) early_ovf++;
        end
        checks++;
        if (early_ovf != 0) begin
            failures++;
            $display("FAIL ovf_early: actual=%0d pulses required=0", early_ovf);
        end
        tick();  // second press completes while pend[1] still set
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_pulse: actual=%b required=1", ovf);
        end
        key = 4'b0000;
        tick();
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_one_cycle: actual=%b required=0", ovf);
        end
        checks++;
        if (valid !== 1'b1 || code !== held) begin
            failures++;
            $display("FAIL ovf_still_held: actual=v%b c%0d required=v1 c%0d", valid, code, held);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL ovf_second_event: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) extra++;
        end
        checks++;
        if (extra != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_no_dup: actual=%0d extra q%0d required=0 q0", extra, exp_q.size());
        end
        $display("test_overflow: done");
    endtask

    task automatic test_set_wins();
        logic [1:0] e;
        do_reset();
        key = 4'b1000;
        for (int i = 0; i < 10; i++) tick();
        exp_q.push_back(2'd3);
        tick();
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL setwin_held: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        key = 4'b0010;
        for (int i = 0; i < 10; i++) tick();  // edge A: pend[1] set
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        key = 4'b0000;
        tick();                                // A+1
        key = 4'b0010;
        for (int i = 0; i < 8; i++) tick();    // A+2 .. A+9
        ack = 1'b1;
        tick();                                // A+10
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL setwin_ack: actual=%b required=0", valid);
        end
        tick();  // A+11: grant of key 1 coincides with its second press
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e || ovf !== 1'b0) begin
            failures++;
            $display("FAIL setwin_grant: actual=v%b c%0d o%b required=v1 c%0d o0", valid, code, ovf, e);
        end
        key = 4'b0000;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL setwin_repend: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        $display("test_set_wins: done");
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        int bad_v = 0;
        do_reset();
        key = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();  // edge 5
        rst = 1'b0;
        checks++;
        if (pressed !== 4'b0000 || valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_cleared: actual=p%b v%b required=p0000 v0", pressed, valid);
        end
        for (int t = 1; t <= 10; t++) begin
            tick();
            checks++;
            if (pressed[0] !== (t == 10)) begin
                failures++;
                $display("FAIL rstmid_pressed_e%0d: actual=%b required=%b", t, pressed[0], (t == 10));
            end
            if (valid) bad_v++;
        end
        checks++;
        if (bad_v != 0) begin
            failures++;
            $display("FAIL rstmid_stale_event: actual=%0d required=0", bad_v);
        end
        exp_q.push_back(2'd0);
        tick();
        e = pop_exp();
        checks++;
        if (valid !== 1'b1 || code !== e) begin
            failures++;
            $display("FAIL rstmid_event: actual=v%b c%0d required=v1 c%0d", valid, code, e);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        key = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        $display("test_reset_mid: done");
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        int exp_t[$];
        int got_t[$];
        int extra = 0;
        logic [1:0] e;
        do_reset();
        key = 4'b1000;
        for (int i = 0; i < 10; i++) tick();  // pressed[3] rises here (P)
        exp_t = '{1, 101, 121, 141};
        for (int i = 0; i < 4; i++) exp_q.push_back(2'd3);
        for (int t = 1; t <= 150; t++) begin
            tick();
            ack = 1'b0;
            if (valid) begin
                got_t.push_back(t);
                e = pop_exp();
                checks++;
                if (code !== e) begin
                    failures++;
                    $display("FAIL repeat_code_t%0d: actual=%0d required=%0d", t, code, e);
                end
                ack = 1'b1;
            end
        end
        checks++;
        if (got_t.size() != exp_t.size()) begin
            failures++;
            $display("FAIL repeat_count: actual=%0d required=%0d", got_t.size(), exp_t.size());
        end
        for (int i = 0; i < exp_t.size() && i < got_t.size(); i++) begin
            checks++;
            if (got_t[i] != exp_t[i]) begin
                failures++;
                $display("FAIL repeat_time_%0d: actual=+%0d required=+%0d", i, got_t[i] - 1, exp_t[i] - 1);
            end
        end
        key = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            tick();
            ack = 1'b0;
            if (valid) begin
                extra++;
                ack = 1'b1;
            end
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL repeat_after_release: actual=%0d required=0", extra);
        end
        $display("test_repeat: done");
    endtask
`endif

    initial begin
        rst = 1'b1;
        key = 4'b0000;
        ack = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_bounce();
        test_same_edge();
        test_overflow();
        test_set_wins();
        test_reset_mid();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
